wave_load_ctrl: RTL and testbench
=================================

# wave_load_ctrl

Sequencing controller placed in front of the `nco` waveform generator. It parses a byte-wide command stream from the host link (valid/ready) and drives the NCO's `we_i`, `data_i` and `freq_step_i`. Table loads are paced so that exactly one NCO strobe falls inside each write window. Between commands it holds the NCO in playback with the last programmed frequency step.

## Interface

Parameters:
- `MAX_ADDR`, 6000: waveform table depth; must match the NCO instance.
- `P_STROBE_MAX`, 520: strobe terminal count; must match the NCO instance. Strobe period is `P_STROBE_MAX+1` cycles.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `s_valid`, in, 1: command byte valid.
- `s_data`, in, 8: command byte.
- `s_ready`, out, 1: controller accepts byte; a transfer occurs when `s_valid && s_ready`.
- `we_o`, out, 1: to NCO `we_i`.
- `data_o`, out, 8: to NCO `data_i`.
- `freq_step_o`, out, 8: to NCO `freq_step_i`.
- `busy_o`, out, 1: high outside `IDLE`.
- `done_o`, out, 1: one-cycle pulse on successful command completion.
- `err_o`, out, 1: one-cycle pulse on a protocol error.

## Operation

- Internal strobe counter, 26 bits, runs free from reset: `0..P_STROBE_MAX` then wraps to 0. `ce` = (count == `P_STROBE_MAX`). Because both blocks share reset release, this counter is cycle-aligned with the NCO strobe.
- Commands (first byte):
  - `0xA5` LOAD: followed by `LEN_LO`, `LEN_HI` (13-bit length, little-endian; `LEN_HI[7:5]` ignored), then LEN data bytes.
  - `0x5A` FREQ: followed by one step byte.
  - Any other first byte: `err_o` pulse, stay in `IDLE`.
- States and transitions:
  - `IDLE` → `LEN_LO` on `0xA5`; `IDLE` → `FREQ` on `0x5A`.
  - `LEN_LO` → `LEN_HI`.
  - `LEN_HI` → `LOAD_WAIT` if 1 ≤ LEN ≤ `MAX_ADDR`. If LEN = 0: `done_o` pulse, go to `IDLE`. If LEN > `MAX_ADDR`: `err_o` pulse, go to `IDLE`.
  - `LOAD_WAIT`: accept a byte, latch it into `data_o`, → `LOAD_ARM`.
  - `LOAD_ARM`: wait for `ce`; on the cycle after `ce`, raise `we_o` → `LOAD_HOLD`.
  - `LOAD_HOLD`: wait for the next `ce`; on the cycle after it, drop `we_o` and decrement the remaining count. Next state is `LOAD_WAIT` if bytes remain, otherwise `DONE`.
  - `FREQ`: accept the byte; `freq_step_o` ← byte, `done_o` pulse, → `IDLE`.
  - `DONE`: `done_o` pulse, → `IDLE`.
- `s_ready` is high only in `IDLE`, `LEN_LO`, `LEN_HI`, `LOAD_WAIT` and `FREQ`.
- Remaining-count register is 13 bits and never underflows: the exit test is remaining == 1 before the decrement.
- Loading does not reset the NCO address. The host issues LOAD after the NCO address has wrapped, or accepts a rotated table.
- `freq_step_o` holds its value through LOAD. The NCO ignores it while `we_i` is high.

## Timing

- Reset values: `s_ready`=0 (1 from the first cycle after reset, in `IDLE`), `we_o`=0, `data_o`=0, `freq_step_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0. State = `IDLE`, strobe count = 0.
- Byte acceptance costs one cycle; `s_ready` drops the cycle after acceptance in `LOAD_WAIT`.
- `we_o` window is exactly `P_STROBE_MAX+1` cycles and contains exactly one `ce`. `data_o` is stable for the whole window.
- Per-byte LOAD cost ranges from `P_STROBE_MAX+3` to `2*(P_STROBE_MAX+1)+1` cycles, depending on strobe phase at acceptance.
- `done_o` and `err_o` are registered and never high together.
- `rst` asserted mid-load: next cycle `we_o`=0, state `IDLE`, strobe counter cleared, `freq_step_o`=1.

## Configuration

- `WAVE_LOAD_CHECKSUM_EN` defined: LOAD carries one extra trailing byte equal to the XOR of all data bytes.
  - Byte is accepted in a `CHECK` state entered after the last `LOAD_HOLD`.
  - Match: `done_o` pulse. Mismatch: `err_o` pulse. The written table is not rolled back.
  - LEN = 0 expects a checksum of `0x00`.
- Undefined: no `CHECK` state; LOAD completes after the last data byte.

## Test plan

- Reset, then idle for 10 cycles → `freq_step_o`=1, `we_o`=0, `busy_o`=0, `s_ready`=1.
- `P_STROBE_MAX`=3; send `5A 07` → `freq_step_o`=7 one cycle after the second byte; single `done_o` pulse.
- `P_STROBE_MAX`=3, `MAX_ADDR`=16; send `A5 03 00 11 22 33` → three `we_o` windows of 4 cycles each, with `data_o` = `11`, `22`, `33`. Exactly one `ce` per window; `done_o` after the third window.
- `A5 00 00` → `done_o` pulse, no `we_o`. `A5 11 00` with `MAX_ADDR`=16 → `err_o`, no `we_o`. Byte `33` in `IDLE` → `err_o`.
- Assert `rst` for 1 cycle during the second `we_o` window → `we_o`=0 next cycle, `busy_o`=0, `freq_step_o`=1. A following `5A 02` completes normally.
- With `WAVE_LOAD_CHECKSUM_EN`: `A5 02 00 0F F0 FF` → `done_o`. `A5 02 00 0F F0 00` → `err_o`.

Source files
------------

// File: rtl/wave_load_ctrl.sv
//==============================================================================
// Module : wave_load_ctrl
// Desc   : Byte-command sequencer in front of the NCO; paces table writes so
//          exactly one NCO strobe falls in each write window.
//          Optional feature macro: WAVE_LOAD_CHECKSUM_EN (trailing XOR byte).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wave_load_ctrl #(
    parameter int MAX_ADDR     = 6000,
    parameter int P_STROBE_MAX = 520
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       we_o,
    output logic [7:0] data_o,
    output logic [7:0] freq_step_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_LOAD_WAIT,
        S_LOAD_ARM,
        S_LOAD_HOLD,
        S_FREQ,
        S_DONE,
        S_CHECK
    } state_t;

    localparam logic [7:0]  C_CMD_LOAD = 8'hA5;
    localparam logic [7:0]  C_CMD_FREQ = 8'h5A;
    localparam logic [25:0] C_CNT_MAX  = 26'(P_STROBE_MAX);
    localparam logic [12:0] C_MAX_LEN  = 13'(MAX_ADDR);

    state_t      r_state;
    state_t      w_next;
    logic [25:0] r_cnt;
    logic [7:0]  r_len_lo;
    logic [12:0] r_rem;
    logic        r_ready;
    logic        r_we;
    logic [7:0]  r_data;
    logic [7:0]  r_freq;
    logic        r_done;
    logic        r_err;
`ifdef WAVE_LOAD_CHECKSUM_EN
    logic [7:0]  r_xor;
`endif

    logic        w_ce;
    logic        w_xfer;
    logic [12:0] w_len;
    logic        w_done;
    logic        w_err;
    logic        w_ready_next;

    // Free-running counter mirrors the NCO strobe since both leave reset together.
    assign w_ce   = (r_cnt == C_CNT_MAX);
    assign w_xfer = s_valid && r_ready;
    assign w_len  = {s_data[4:0], r_len_lo};

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (s_data == C_CMD_LOAD) begin
                        w_next = S_LEN_LO;
                    end else if (s_data == C_CMD_FREQ) begin
                        w_next = S_FREQ;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    w_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len == 13'd0) begin
`ifdef WAVE_LOAD_CHECKSUM_EN
                        w_next = S_CHECK;
`else
                        w_done = 1'b1;
                        w_next = S_IDLE;
`endif
                    end else if (w_len > C_MAX_LEN) begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_LOAD_WAIT;
                    end
                end
            end
            S_LOAD_WAIT: begin
                if (w_xfer) begin
                    w_next = S_LOAD_ARM;
                end
            end
            S_LOAD_ARM: begin
                if (w_ce) begin
                    w_next = S_LOAD_HOLD;
                end
            end
            S_LOAD_HOLD: begin
                if (w_ce) begin
                    if (r_rem == 13'd1) begin
`ifdef WAVE_LOAD_CHECKSUM_EN
                        w_next = S_CHECK;
`else
                        w_next = S_DONE;
`endif
                    end else begin
                        w_next = S_LOAD_WAIT;
                    end
                end
            end
            S_FREQ: begin
                if (w_xfer) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
`ifdef WAVE_LOAD_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) begin
                    if (s_data == r_xor) begin
                        w_done = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign w_ready_next = (w_next == S_IDLE)      || (w_next == S_LEN_LO) ||
                          (w_next == S_LEN_HI)    || (w_next == S_FREQ)   ||
                          (w_next == S_LOAD_WAIT) || (w_next == S_CHECK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len_lo <= '0;
            r_rem    <= '0;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_data   <= '0;
            r_freq   <= 8'd1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
`ifdef WAVE_LOAD_CHECKSUM_EN
            r_xor    <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= w_ce ? '0 : r_cnt + 26'd1;
            r_ready <= w_ready_next;
            r_done  <= w_done;
            r_err   <= w_err;
            if (r_state == S_LEN_LO && w_xfer) begin
                r_len_lo <= s_data;
            end
            if (r_state == S_LEN_HI && w_xfer) begin
                r_rem <= w_len;
`ifdef WAVE_LOAD_CHECKSUM_EN
                r_xor <= '0;
`endif
            end
            if (r_state == S_LOAD_WAIT && w_xfer) begin
                r_data <= s_data;
`ifdef WAVE_LOAD_CHECKSUM_EN
                r_xor  <= r_xor ^ s_data;
`endif
            end
            // Window opens after one strobe and closes after the next one.
            if (r_state == S_LOAD_ARM && w_ce) begin
                r_we <= 1'b1;
            end
            if (r_state == S_LOAD_HOLD && w_ce) begin
                r_we  <= 1'b0;
                r_rem <= r_rem - 13'd1;
            end
            if (r_state == S_FREQ && w_xfer) begin
                r_freq <= s_data;
            end
        end
    end

    assign s_ready     = r_ready;
    assign we_o        = r_we;
    assign data_o      = r_data;
    assign freq_step_o = r_freq;
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wave_load_ctrl.sv
// Self-checking bench for wave_load_ctrl: timeline-based reference model plus
// directed and randomized command streams.
`default_nettype none

module tb_wave_load_ctrl;

    localparam int P    = 3;
    localparam int MAXA = 16;
`ifdef WAVE_LOAD_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    localparam int M_CMD = 0, M_LO = 1, M_HI = 2, M_DATA = 3, M_STEP = 4, M_CHK = 5, M_WAIT = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, we_o, busy_o, done_o, err_o;
    logic [7:0] data_o, freq_step_o;

    wave_load_ctrl #(.MAX_ADDR(MAXA), .P_STROBE_MAX(P)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .we_o(we_o), .data_o(data_o), .freq_step_o(freq_step_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs for the current cycle k, where k counts
    // cycles since reset release (strobe fires when k % (P+1) == P).
    bit         started = 1'b0;
    bit         just_rst;
    bit         m_xfer;
    int         k, mode, resume_at, resume_mode, rem, len, c;
    logic [7:0] lo, mx, e_data, e_freq, b;
    int         we_lo, we_hi, done_at, err_at;

    bit         prev_we = 1'b0;
    int         cur_len, cur_ce;
    int         win_len[$];
    int         win_ce[$];
    int         win_data[$];
    int         done_cnt = 0, err_cnt = 0, we_cycles = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("s_ready", int'(s_ready), int'(!just_rst && mode != M_WAIT));
            chk("we_o", int'(we_o), int'(k >= we_lo && k <= we_hi));
            chk("data_o", int'(data_o), int'(e_data));
            chk("freq_step_o", int'(freq_step_o), int'(e_freq));
            chk("busy_o", int'(busy_o), int'(mode != M_CMD));
            chk("done_o", int'(done_o), int'(k == done_at));
            chk("err_o", int'(err_o), int'(k == err_at));
            if (we_o) begin
                if (!prev_we) begin
                    cur_len = 0;
                    cur_ce  = 0;
                    win_data.push_back(int'(data_o));
                end
                cur_len++;
                we_cycles++;
                if (k % (P + 1) == P) cur_ce++;
            end else if (prev_we) begin
                win_len.push_back(cur_len);
                win_ce.push_back(cur_ce);
            end
            prev_we = we_o;
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
        end
        if (rst) begin
            started  = 1'b1;
            just_rst = 1'b1;
            k        = 0;
            mode     = M_CMD;
            e_data   = 8'h00;
            e_freq   = 8'h01;
            we_lo    = -10;
            we_hi    = -10;
            done_at  = -10;
            err_at   = -10;
            prev_we  = 1'b0;
        end else if (started) begin
            m_xfer = s_valid && !just_rst && mode != M_WAIT;
            b      = s_data;
            if (m_xfer) begin
                case (mode)
                    M_CMD: begin
                        if (b == 8'hA5) mode = M_LO;
                        else if (b == 8'h5A) mode = M_STEP;
                        else err_at = k + 1;
                    end
                    M_LO: begin
                        lo   = b;
                        mode = M_HI;
                    end
                    M_HI: begin
                        len = (int'(b) % 32) * 256 + int'(lo);
                        mx  = 8'h00;
                        if (len == 0) begin
                            if (CK) mode = M_CHK;
                            else begin
                                done_at = k + 1;
                                mode    = M_CMD;
                            end
                        end else if (len > MAXA) begin
                            err_at = k + 1;
                            mode   = M_CMD;
                        end else begin
                            rem  = len;
                            mode = M_DATA;
                        end
                    end
                    M_DATA: begin
                        e_data = b;
                        mx     = mx ^ b;
                        c      = k + 1;
                        while (c % (P + 1) != P) c++;
                        we_lo  = c + 1;
                        we_hi  = c + P + 1;
                        rem--;
                        mode   = M_WAIT;
                        if (rem > 0) begin
                            resume_at   = we_hi + 1;
                            resume_mode = M_DATA;
                        end else if (CK) begin
                            resume_at   = we_hi + 1;
                            resume_mode = M_CHK;
                        end else begin
                            resume_at   = we_hi + 2;
                            resume_mode = M_CMD;
                            done_at     = we_hi + 2;
                        end
                    end
                    M_STEP: begin
                        e_freq  = b;
                        done_at = k + 1;
                        mode    = M_CMD;
                    end
                    M_CHK: begin
                        if (b == mx) done_at = k + 1;
                        else err_at = k + 1;
                        mode = M_CMD;
                    end
                    default: mode = M_CMD;
                endcase
            end
            k++;
            just_rst = 1'b0;
            if (mode == M_WAIT && k >= resume_at) mode = resume_mode;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        chk("byte_accepted", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (!busy_o) ok = 1'b1;
        end
        chk("returns_idle", int'(ok), 1);
        idle(2);
    endtask

    task automatic rsend(input logic [7:0] v);
        idle($urandom_range(0, 2));
        send(v);
    endtask

    int d0, e0, w0, q0, n;
    logic [7:0] x, v, hi;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        idle(10);
        @(negedge clk);
        chk("reset_freq", int'(freq_step_o), 1);
        chk("reset_we", int'(we_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_ready", int'(s_ready), 1);
        idle(1);

        d0 = done_cnt;
        send(8'h5A);
        send(8'h07);
        chk("freq_after_5A07", int'(freq_step_o), 7);
        idle(3);
        chk("freq_done_pulses", done_cnt - d0, 1);

        d0 = done_cnt; q0 = win_len.size();
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
`ifdef WAVE_LOAD_CHECKSUM_EN
        wait_idle();
        send(8'h11 ^ 8'h22 ^ 8'h33);
`endif
        wait_idle();
        chk("load_windows", win_len.size() - q0, 3);
        if (win_len.size() - q0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("window_len", win_len[q0 + i], 4);
                chk("window_ce", win_ce[q0 + i], 1);
            end
            chk("window_data0", win_data[q0], 'h11);
            chk("window_data1", win_data[q0 + 1], 'h22);
            chk("window_data2", win_data[q0 + 2], 'h33);
        end
        chk("load_done_pulses", done_cnt - d0, 1);

        d0 = done_cnt; e0 = err_cnt; w0 = we_cycles;
        send(8'hA5); send(8'h00); send(8'h00);
        if (CK) send(8'h00);
        idle(3);
        chk("len0_done", done_cnt - d0, 1);
        send(8'hA5); send(8'h11); send(8'h00);
        idle(3);
        chk("len17_err", err_cnt - e0, 1);
        send(8'h33);
        idle(3);
        chk("badcmd_err", err_cnt - e0, 2);
        chk("no_we_on_short", we_cycles - w0, 0);

`ifdef WAVE_LOAD_CHECKSUM_EN
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5); send(8'h02); send(8'h00); send(8'h0F); send(8'hF0);
        wait_idle(); send(8'hFF); idle(3);
        chk("checksum_ok", done_cnt - d0, 1);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h0F); send(8'hF0);
        wait_idle(); send(8'h00); idle(3);
        chk("checksum_bad", err_cnt - e0, 1);
`endif

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    v = 8'($urandom);
                    if (v == 8'hA5 || v == 8'h5A) v = 8'h00;
                    rsend(v);
                end
                2, 3, 4: begin
                    rsend(8'h5A);
                    rsend(8'($urandom));
                end
                5, 6, 7, 8: begin
                    n  = $urandom_range(1, 4);
                    hi = 8'($urandom_range(0, 7) * 32);
                    rsend(8'hA5); rsend(8'(n)); rsend(hi);
                    x = 8'h00;
                    for (int j = 0; j < n; j++) begin
                        v = 8'($urandom);
                        x = x ^ v;
                        rsend(v);
                    end
                    if (CK) rsend(($urandom_range(0, 1) == 0) ? x : ~x);
                end
                default: begin
                    n = $urandom_range(MAXA + 1, 8191);
                    rsend(8'hA5); rsend(8'(n % 256)); rsend(8'(n / 256));
                end
            endcase
        end
        wait_idle();

        q0 = win_data.size();
        send(8'hA5); send(8'h03); send(8'h00); send(8'h11); send(8'h22);
        for (int i = 0; i < 300 && win_data.size() < q0 + 2; i++) @(negedge clk);
        chk("second_window_seen", win_data.size() - q0, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_we", int'(we_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_freq", int'(freq_step_o), 1);
        idle(2);
        d0 = done_cnt;
        send(8'h5A); send(8'h02);
        chk("post_rst_freq", int'(freq_step_o), 2);
        idle(3);
        chk("post_rst_done", done_cnt - d0, 1);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
